// File: rtl/sat_narrow_pkg.sv
// Shared types and saturation-bound helpers for the narrowing datapath.
package sat_narrow_pkg;

  localparam int unsigned NARROW_BITS = 6;
  localparam int unsigned HELPER_BITS = 32;

  typedef enum logic {
    NARROW_WRAP = 1'b0,
    NARROW_SAT  = 1'b1
  } narrow_mode_e;

  // Buffer entry; data width follows NARROW_BITS, so OUT_BITS must match it.
  typedef struct packed {
    logic [NARROW_BITS-1:0] data;
    logic                   ovf;
  } narrow_entry_t;

  // Largest positive value of a bits-wide two's complement field (0 then all 1s).
  function automatic logic [HELPER_BITS-1:0] sat_max(input int unsigned bits);
    return (HELPER_BITS'(1) << (bits - 1)) - HELPER_BITS'(1);
  endfunction

  // Most negative value of a bits-wide two's complement field (1 then all 0s).
  function automatic logic [HELPER_BITS-1:0] sat_min(input int unsigned bits);
    return HELPER_BITS'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/sat_narrow_core.sv
// Combinational narrowing: fit test plus saturate-or-wrap of a 2*OUT_BITS value.
module narrow_core
  import sat_narrow_pkg::*;
#(
  parameter int unsigned OUT_BITS = NARROW_BITS
) (
  input  logic [2*OUT_BITS-1:0] in_data,
  input  logic                  sat_mode,
  output logic [OUT_BITS-1:0]   data_c,
  output logic                  ovf_c
);

  localparam int unsigned IN_BITS = 2 * OUT_BITS;

  logic [OUT_BITS:0] upper;
  logic              fits;
  narrow_mode_e      mode;

  // Value fits when the discarded bits all replicate the new sign bit.
  assign upper = in_data[IN_BITS-1:OUT_BITS-1];
  assign fits  = (&upper) || (~|upper);
  assign mode  = narrow_mode_e'(sat_mode);

  always_comb begin
    data_c = in_data[OUT_BITS-1:0];
    ovf_c  = 1'b0;
    if (!fits) begin
      ovf_c = 1'b1;
      if (mode == NARROW_SAT) begin
        data_c = in_data[IN_BITS-1] ? OUT_BITS'(sat_min(OUT_BITS))
                                    : OUT_BITS'(sat_max(OUT_BITS));
      end
    end
  end

endmodule

// File: rtl/sat_narrow.sv
// Streaming narrowing unit: 2-entry output buffer, sticky overflow flag and counter.
module sat_narrow
  import sat_narrow_pkg::*;
#(
  parameter int unsigned OUT_BITS = NARROW_BITS,
  parameter int unsigned CNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*OUT_BITS-1:0] in_data,
  input  logic                  sat_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_BITS-1:0]   out_data,
  output logic                  out_ovf,
  output logic                  ovf_sticky,
  input  logic                  clr_sticky,
  output logic [CNT_BITS-1:0]   ovf_count
);

  narrow_entry_t       new_entry;
  narrow_entry_t       slot0_q, slot0_n;
  narrow_entry_t       slot1_q, slot1_n;
  logic [1:0]          count_q, count_n;
  logic                sticky_n;
  logic [CNT_BITS-1:0] cnt_n;
  logic                push, pop;

  narrow_core #(.OUT_BITS(OUT_BITS)) u_core (
    .in_data  (in_data),
    .sat_mode (sat_mode),
    .data_c   (new_entry.data),
    .ovf_c    (new_entry.ovf)
  );

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // slot0 is always the head, so out_data/out_ovf come straight from a register.
  always_comb begin
    slot0_n = slot0_q;
    slot1_n = slot1_q;
    count_n = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          slot0_n = new_entry;
          count_n = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          slot0_n = new_entry;
        end else if (push) begin
          slot1_n = new_entry;
          count_n = 2'd2;
        end else if (pop) begin
          count_n = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          slot0_n = slot1_q;
          count_n = 2'd1;
        end
      end
    endcase
  end

  // Clear wins over a same-cycle overflow, which is then not counted.
  always_comb begin
    sticky_n = ovf_sticky;
    cnt_n    = ovf_count;
    if (clr_sticky) begin
      sticky_n = 1'b0;
      cnt_n    = '0;
    end else if (push && new_entry.ovf) begin
      sticky_n = 1'b1;
      if (ovf_count != {CNT_BITS{1'b1}}) begin
        cnt_n = ovf_count + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      count_q    <= 2'd0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else begin
      slot0_q    <= slot0_n;
      slot1_q    <= slot1_n;
      count_q    <= count_n;
      out_valid  <= (count_n != 2'd0);
      in_ready   <= (count_n != 2'd2);
      ovf_sticky <= sticky_n;
      ovf_count  <= cnt_n;
    end
  end

  assign out_data = slot0_q.data;
  assign out_ovf  = slot0_q.ovf;

endmodule

// File: tb/tb_sat_narrow.sv
// Bench for sat_narrow: directed streams plus random traffic against a queue-based model.
module tb_sat_narrow;

  localparam int unsigned OB = 6;
  localparam int unsigned CB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [11:0]   in_data = '0;
  logic          sat_mode = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OB-1:0] out_data;
  logic          out_ovf;
  logic          ovf_sticky;
  logic          clr_sticky = 1'b0;
  logic [CB-1:0] ovf_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: FIFO of {ovf, data}, expected in_ready, sticky, counter.
  logic [6:0] q[$];
  logic       m_ready  = 1'b0;
  logic       m_sticky = 1'b0;
  logic [7:0] m_cnt    = '0;

  always #5 clk = ~clk;

  sat_narrow #(.OUT_BITS(OB), .CNT_BITS(CB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sat_mode   (sat_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky),
    .ovf_count  (ovf_count)
  );

  // Reference narrowing done on the integer value: range check, then clamp or truncate.
  function automatic logic [6:0] ref_narrow(input logic [11:0] x, input logic sat);
    int         v;
    logic       o;
    logic [5:0] d;
    v = $signed(x);
    o = (v > 31) || (v < -32);
    d = x[5:0];
    if (o && sat) d = (v > 0) ? 6'd31 : 6'h20;
    return {o, d};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // One clock: advance the model with the current inputs, then compare everything.
  task automatic step();
    logic       acc, pp;
    logic [6:0] e;
    acc = in_valid && m_ready;
    pp  = (q.size() != 0) && out_ready;
    e   = ref_narrow(in_data, sat_mode);
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_sticky = 1'b0;
      m_cnt    = '0;
      m_ready  = 1'b0;
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (clr_sticky) begin
        m_sticky = 1'b0;
        m_cnt    = '0;
      end else if (acc && e[6]) begin
        m_sticky = 1'b1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end
      m_ready = (q.size() < 2);
    end
    check_eq("in_ready", 32'(in_ready), 32'(m_ready));
    check_eq("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("out_data", 32'(out_data), 32'(q[0][5:0]));
      check_eq("out_ovf", 32'(out_ovf), 32'(q[0][6]));
    end
    check_eq("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
    check_eq("ovf_count", 32'(ovf_count), 32'(m_cnt));
  endtask

  // Offer one beat until accepted, bounded.
  task automatic send(input logic [11:0] d, input logic s);
    logic a;
    a        = 1'b0;
    in_data  = d;
    sat_mode = s;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = m_ready;
      step();
      if (a) break;
    end
    if (!a) check_eq("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    check_eq("rst_count", 32'(ovf_count), 32'(0));
    rst = 1'b0;
    step();

    // Values at the edge of the range, saturate mode.
    out_ready = 1'b1;
    send(12'h01F, 1'b1);
    send(12'hFE0, 1'b1);
    step();
    // Just out of range, saturate mode.
    send(12'h020, 1'b1);
    send(12'hFDF, 1'b1);
    step();
    check_eq("sat_count2", 32'(ovf_count), 32'(2));
    // Wrap mode.
    send(12'h020, 1'b0);
    send(12'hF9F, 1'b0);
    send(12'h7FF, 1'b0);
    step();

    // Backpressure: third beat held until the consumer drains.
    out_ready = 1'b0;
    send(12'h001, 1'b1);
    send(12'h002, 1'b1);
    in_data  = 12'h003;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("bp_in_ready", 32'(in_ready), 32'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 8 && in_valid; i++) begin
      if (m_ready) in_valid_drop();
      else step();
    end
    for (int i = 0; i < 3; i++) step();

    // Counter saturation, then clear racing an overflow.
    for (int i = 0; i < 300; i++) send(12'h400, 1'b1);
    check_eq("cnt_sat", 32'(ovf_count), 32'hFF);
    clr_sticky = 1'b1;
    send(12'hC00, 1'b1);
    clr_sticky = 1'b0;
    check_eq("clr_count", 32'(ovf_count), 32'(0));
    check_eq("clr_sticky", 32'(ovf_sticky), 32'(0));
    step();

    // Reset while the buffer is full.
    out_ready = 1'b0;
    send(12'h400, 1'b1);
    send(12'h009, 1'b1);
    rst = 1'b1;
    step();
    check_eq("rst_in_ready", 32'(in_ready), 32'(0));
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    rst = 1'b0;
    step();
    check_eq("post_rst_ready", 32'(in_ready), 32'(1));
    out_ready = 1'b1;
    send(12'h005, 1'b1);
    check_eq("post_rst_data", 32'(out_data), 32'h05);
    step();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      sat_mode   = 1'($urandom_range(0, 1));
      clr_sticky = ($urandom_range(0, 31) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) in_data = 12'($urandom_range(0, 80)) - 12'd40;
      else in_data = 12'($urandom);
      step();
    end
    rst        = 1'b0;
    in_valid   = 1'b0;
    clr_sticky = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Final cycle of a held beat: it is accepted on this edge, then withdrawn.
  task automatic in_valid_drop();
    step();
    in_valid = 1'b0;
  endtask

endmodule

// File: doc/sat_narrow.md
Name: sat_narrow

Overview:
- Narrowing unit: the inverse of the datapath sign-extension stage. Takes a 2*OUT_BITS signed value and returns an OUT_BITS signed result.
- Detects when the value does not fit in OUT_BITS. Either saturates or wraps, per the mode input.
- Streams through a valid/ready handshake with a 2-entry output buffer.
- Keeps a sticky overflow flag and a saturating overflow event counter.
- Sits between ALU/multiplier results and narrow immediate/register-field writeback.

Parameters:
- OUT_BITS, 6, width of the narrowed result; input width is 2*OUT_BITS.
- CNT_BITS, 8, width of the overflow event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is presented.
- in_ready  output  1  unit accepts in_data this cycle.
- in_data  input  2*OUT_BITS  signed value to narrow.
- sat_mode  input  1  1 = saturate, 0 = wrap (truncate); sampled with the accepted beat.
- out_valid  output  1  buffer head is valid.
- out_ready  input  1  consumer takes the head this cycle.
- out_data  output  OUT_BITS  narrowed result at the buffer head.
- out_ovf  output  1  the head sample did not fit.
- ovf_sticky  output  1  set on any accepted overflow; held until cleared.
- clr_sticky  input  1  clears ovf_sticky and ovf_count.
- ovf_count  output  CNT_BITS  number of accepted overflows, saturating.

Behaviour:
- Reset: in_ready=0 during the reset cycle, then 1. out_valid=0, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0, buffer count=0.
- Accept: a beat is accepted when in_valid && in_ready. Result is visible at out_valid one cycle later when the buffer was empty or its head was popped the same cycle.
- Pop: occurs when out_valid && out_ready.
- Fit test: fits iff in_data[2*OUT_BITS-1 : OUT_BITS-1] are all 0s or all 1s.
- Fits: out_data = in_data[OUT_BITS-1:0], ovf=0.
- Does not fit, sat_mode=1: positive input (MSB 0) gives 0 followed by all 1s (6'h1F); negative input gives 1 followed by all 0s (6'h20). ovf=1.
- Does not fit, sat_mode=0: out_data = in_data[OUT_BITS-1:0], ovf=1.
- Buffer: 2-entry FIFO of {data, ovf}, in order.
- in_ready is registered: in_ready = (count < 2). It does not depend combinationally on out_ready.
- count 0: push only.
- count 1: push+pop keeps count 1, and the new entry becomes the head next cycle.
- count 2: in_ready=0, so a pop alone brings count to 1.
- Holding: out_data and out_ovf stay stable while out_valid && !out_ready.
- Sticky/counter: on an accepted beat with ovf=1, ovf_sticky<=1 and ovf_count increments, holding at all-ones.
- clr_sticky: takes priority over a same-cycle overflow. Both are cleared, and that overflow is not counted.
- Reset mid-operation: buffered entries are discarded and all outputs return to reset values the next cycle. No partial beat is emitted.

Decomposition:
- Package sat_narrow_pkg:
  - typedef narrow_mode_e {NARROW_WRAP=0, NARROW_SAT=1};
  - function or constant helpers for SAT_MAX / SAT_MIN built from OUT_BITS;
  - packed struct typedef {data, ovf} for the buffer entry.
- One combinational sub-module narrow_core: in_data and mode to data and ovf. It holds the fit test and saturation and is reusable by the writeback stage.
- The top holds the FIFO, handshake, sticky flag and counter.

Test Plan:
1. Fits, sat mode: OUT_BITS=6, sat_mode=1, stream 12'h01F, 12'hFE0, out_ready=1 -> out_data 6'h1F, 6'h20 one cycle after each accept; out_ovf=0; ovf_count=0.
2. Saturate: sat_mode=1, in 12'h020 then 12'hFDF -> 6'h1F ovf=1, then 6'h20 ovf=1; ovf_sticky=1, ovf_count=2.
3. Wrap: sat_mode=0, in 12'h020 and 12'hF9F -> 6'h20 ovf=1 and 6'h1F ovf=1; in 12'h7FF -> 6'h3F ovf=1.
4. Backpressure: out_ready=0, offer 3 beats (12'h001, 12'h002, 12'h003) -> in_ready drops after 2 accepts, third held. Raise out_ready -> outputs 6'h01, 6'h02, 6'h03 in order, none lost or duplicated.
5. Counter/clear: CNT_BITS=8, 300 overflow beats -> ovf_count saturates at 8'hFF. Assert clr_sticky together with one overflow beat -> next cycle ovf_count=0 and ovf_sticky=0; the beat is still delivered with out_ovf=1.
6. Reset mid-stream: buffer holding 2 entries, pulse rst one cycle -> next cycle out_valid=0, ovf_count=0, ovf_sticky=0, in_ready=0 during the reset cycle and 1 after. Subsequent 12'h005 -> 6'h05.
